// File: rtl/r5fp_idiv_seq.sv
// Sequential fractional divider: quo = floor(N*2^(W-1)/D), rem = N*2^(W-1) mod D.
// Two restoring steps per cycle, W/2 busy cycles, one-cycle done pulse.
module r5fp_idiv_seq #(
    parameter int W = 26
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] N_i,
    input  logic [W-1:0] D_i,
    input  logic         strobe_i,
    output logic [W-1:0] quo_o,
    output logic [W-1:0] rem_o,
    output logic         done_o,
    output logic         ready_o
);

    localparam int CW = $clog2(W / 2 + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(W / 2);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [W-1:0]   r_q, r_d;
    logic [W-1:0]   dq_q, dq_d;
    logic [W-1:0]   qacc_q, qacc_d;
    logic [W-1:0]   quo_q, quo_d;
    logic [W-1:0]   rem_q, rem_d;

    logic [W-1:0]   r0_s, s0_s, r1_s, s1_s;
    logic [W:0]     t0_s, t1_s;
    logic           q0_s, q1_s;
    logic           accept_s;

    // Datapath: two chained restoring steps; the very first step of an op uses R unshifted
    always_comb begin
        r0_s = (cnt_q == CNT_INIT) ? r_q : {r_q[W-2:0], 1'b0};
        t0_s = {1'b0, r0_s} - {1'b0, dq_q};
        q0_s = ~t0_s[W];
        s0_s = q0_s ? t0_s[W-1:0] : r0_s;
        r1_s = {s0_s[W-2:0], 1'b0};
        t1_s = {1'b0, r1_s} - {1'b0, dq_q};
        q1_s = ~t1_s[W];
        s1_s = q1_s ? t1_s[W-1:0] : r1_s;
    end

    assign accept_s = strobe_i && ((state_q == IDLE) || (state_q == DONE));

    // Next-state and register-update logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        r_d     = r_q;
        dq_d    = dq_q;
        qacc_d  = qacc_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        case (state_q)
            IDLE, DONE: begin
                if (accept_s) begin
                    r_d     = N_i;
                    dq_d    = D_i;
                    qacc_d  = {W{1'b0}};
                    cnt_d   = CNT_INIT;
                    state_d = BUSY;
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                r_d    = s1_s;
                qacc_d = {qacc_q[W-3:0], q0_s, q1_s};
                cnt_d  = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    quo_d   = {qacc_q[W-3:0], q0_s, q1_s};
                    rem_d   = s1_s;
                    state_d = DONE;
                end else begin
                    state_d = BUSY;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= {CW{1'b0}};
            r_q     <= {W{1'b0}};
            dq_q    <= {W{1'b0}};
            qacc_q  <= {W{1'b0}};
            quo_q   <= {W{1'b0}};
            rem_q   <= {W{1'b0}};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            r_q     <= r_d;
            dq_q    <= dq_d;
            qacc_q  <= qacc_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
        end
    end

    assign quo_o   = quo_q;
    assign rem_o   = rem_q;
    assign done_o  = (state_q == DONE);
    assign ready_o = (state_q == IDLE) || (state_q == DONE);

endmodule

// File: tb/tb_r5fp_idiv_seq.sv
// Directed and randomised checks of r5fp_idiv_seq at W=8 and W=26.
module tb_r5fp_idiv_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [7:0]  n8, d8, quo8, rem8;
    logic        stb8, done8, rdy8;
    logic [25:0] n26, d26, quo26, rem26;
    logic        stb26, done26, rdy26;

    int total = 0;
    int bad   = 0;

    r5fp_idiv_seq #(.W(8)) dut8 (
        .clk(clk), .reset(reset), .N_i(n8), .D_i(d8), .strobe_i(stb8),
        .quo_o(quo8), .rem_o(rem8), .done_o(done8), .ready_o(rdy8)
    );

    r5fp_idiv_seq #(.W(26)) dut26 (
        .clk(clk), .reset(reset), .N_i(n26), .D_i(d26), .strobe_i(stb26),
        .quo_o(quo26), .rem_o(rem26), .done_o(done26), .ready_o(rdy26)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Strobe one W=8 op and stop in the cycle where done8 is seen.
    task automatic run8(input logic [7:0] n, input logic [7:0] d, output int lat, output logic ok);
        n8 = n; d8 = d; stb8 = 1'b1;
        step();
        stb8 = 1'b0;
        lat = 1; ok = 1'b0;
        while (!ok && lat < 30) begin
            if (done8) ok = 1'b1;
            else begin step(); lat++; end
        end
    endtask

    task automatic run26(input logic [25:0] n, input logic [25:0] d, output int lat, output logic ok);
        n26 = n; d26 = d; stb26 = 1'b1;
        step();
        stb26 = 1'b0;
        lat = 1; ok = 1'b0;
        while (!ok && lat < 40) begin
            if (done26) ok = 1'b1;
            else begin step(); lat++; end
        end
    endtask

    task automatic test_reset();
        int pulses;
        reset = 1'b1;
        stb8 = 1'b0; n8 = 8'h00; d8 = 8'h40;
        stb26 = 1'b0; n26 = 26'h0; d26 = 26'h1000000;
        step(); step(); step();
        reset = 1'b0;
        total++; if (rdy26 !== 1'b1) begin bad++; $display("FAIL reset_ready26 got=%b exp=1", rdy26); end
        total++; if (done26 !== 1'b0) begin bad++; $display("FAIL reset_done26 got=%b exp=0", done26); end
        total++; if (quo26 !== 26'h0) begin bad++; $display("FAIL reset_quo26 got=%h exp=0", quo26); end
        total++; if (rem26 !== 26'h0) begin bad++; $display("FAIL reset_rem26 got=%h exp=0", rem26); end
        total++; if (rdy8 !== 1'b1 || done8 !== 1'b0) begin bad++; $display("FAIL reset_w8 rdy=%b done=%b exp rdy=1 done=0", rdy8, done8); end
        pulses = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (done26 === 1'b1) pulses++;
        end
        total++; if (pulses !== 0) begin bad++; $display("FAIL idle_no_done got=%0d pulses exp=0", pulses); end
    endtask

    task automatic test_basic();
        int lat;
        logic early;
        n8 = 8'h20; d8 = 8'h40; stb8 = 1'b1;
        step();
        stb8 = 1'b0;
        early = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            if (rdy8 !== 1'b0 || done8 !== 1'b0) early = 1'b1;
            step();
        end
        total++; if (early !== 1'b0) begin bad++; $display("FAIL busy_ready_low got ready/done high in cycles 1-4 exp low"); end
        lat = 5;
        total++; if (done8 !== 1'b1) begin bad++; $display("FAIL basic_done_c5 got=%b exp=1 at cycle %0d", done8, lat); end
        total++; if (quo8 !== 8'h40) begin bad++; $display("FAIL basic_quo got=%h exp=40", quo8); end
        total++; if (rem8 !== 8'h00) begin bad++; $display("FAIL basic_rem got=%h exp=00", rem8); end
        step();
        total++; if (done8 !== 1'b0 || rdy8 !== 1'b1) begin bad++; $display("FAIL done_to_idle done=%b rdy=%b exp done=0 rdy=1", done8, rdy8); end
    endtask

    task automatic test_values();
        int lat;
        logic ok;
        logic [7:0] nv [3] = '{8'h30, 8'h00, 8'h4F};
        logic [7:0] dv [3] = '{8'h50, 8'h7F, 8'h50};
        logic [7:0] qv [3] = '{8'h4C, 8'h00, 8'h7E};
        logic [7:0] rv [3] = '{8'h40, 8'h00, 8'h20};
        for (int k = 0; k < 3; k++) begin
            run8(nv[k], dv[k], lat, ok);
            total++; if (!ok || lat !== 5) begin bad++; $display("FAIL val%0d_latency got=%0d ok=%b exp=5", k, lat, ok); end
            total++; if (quo8 !== qv[k]) begin bad++; $display("FAIL val%0d_quo got=%h exp=%h", k, quo8, qv[k]); end
            total++; if (rem8 !== rv[k]) begin bad++; $display("FAIL val%0d_rem got=%h exp=%h", k, rem8, rv[k]); end
            step();
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        logic ok;
        logic held;
        run8(8'h30, 8'h50, lat, ok);
        total++; if (!ok || quo8 !== 8'h4C) begin bad++; $display("FAIL b2b_first ok=%b quo=%h exp 4C", ok, quo8); end
        n8 = 8'h20; d8 = 8'h40; stb8 = 1'b1;
        step();
        stb8 = 1'b0;
        total++; if (rdy8 !== 1'b0) begin bad++; $display("FAIL b2b_accept rdy=%b exp=0 (busy)", rdy8); end
        step();
        n8 = 8'h10; d8 = 8'h7F; stb8 = 1'b1;
        step();
        stb8 = 1'b0;
        lat = 3; ok = 1'b0; held = 1'b1;
        while (!ok && lat < 30) begin
            if (done8) ok = 1'b1;
            else begin
                if (quo8 !== 8'h4C) held = 1'b0;
                step(); lat++;
            end
        end
        total++; if (held !== 1'b1) begin bad++; $display("FAIL b2b_hold quo changed while busy exp 4C"); end
        total++; if (!ok || lat !== 5) begin bad++; $display("FAIL b2b_latency got=%0d ok=%b exp=5", lat, ok); end
        total++; if (quo8 !== 8'h40 || rem8 !== 8'h00) begin bad++; $display("FAIL b2b_result quo=%h rem=%h exp 40/00", quo8, rem8); end
        step();
    endtask

    task automatic test_reset_mid();
        int lat;
        int pulses;
        logic ok;
        n8 = 8'h30; d8 = 8'h50; stb8 = 1'b1;
        step();
        stb8 = 1'b0;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        total++; if (done8 !== 1'b0 || rdy8 !== 1'b1) begin bad++; $display("FAIL midrst_state done=%b rdy=%b exp 0/1", done8, rdy8); end
        total++; if (quo8 !== 8'h00 || rem8 !== 8'h00) begin bad++; $display("FAIL midrst_clear quo=%h rem=%h exp 00/00", quo8, rem8); end
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (done8 === 1'b1) pulses++;
        end
        total++; if (pulses !== 0) begin bad++; $display("FAIL midrst_no_done got=%0d exp=0", pulses); end
        run8(8'h30, 8'h50, lat, ok);
        total++; if (!ok || lat !== 5 || quo8 !== 8'h4C || rem8 !== 8'h40) begin
            bad++; $display("FAIL midrst_next ok=%b lat=%0d quo=%h rem=%h exp 5/4C/40", ok, lat, quo8, rem8);
        end
        step();
    endtask

    task automatic test_random26();
        int lat;
        logic ok;
        logic [22:0] dr, a;
        logic [25:0] n, d, eq, er;
        longint num;
        for (int k = 0; k < 2000; k++) begin
            dr = 23'($urandom);
            d = {2'b01, dr, 1'b0};
            if ($urandom_range(0, 1) == 0 && dr != 23'd0) begin
                a = 23'($urandom_range(0, int'(dr) - 1));
                n = {2'b01, a, 1'b0};
            end else begin
                n = {3'b001, 23'($urandom)};
            end
            num = longint'(n) << 25;
            eq = 26'(num / longint'(d));
            er = 26'(num % longint'(d));
            run26(n, d, lat, ok);
            total++; if (!ok || lat !== 14) begin bad++; $display("FAIL rnd%0d_latency got=%0d ok=%b exp=14", k, lat, ok); end
            total++; if (quo26 !== eq) begin bad++; $display("FAIL rnd%0d_quo n=%h d=%h got=%h exp=%h", k, n, d, quo26, eq); end
            total++; if (rem26 !== er) begin bad++; $display("FAIL rnd%0d_rem n=%h d=%h got=%h exp=%h", k, n, d, rem26, er); end
        end
        step();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_values();
        test_back_to_back();
        test_reset_mid();
        test_random26();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
